rr_arbiter4: RTL and testbench
==============================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 8, meaning: maximum cycles a contended grant is held; used only with RR_ARB_TIMEOUT_EN; legal range 1..255.
REQ-002 clk  input  1  single clock, rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  request lines; req[i] belongs to requester i.
REQ-005 gnt  output  4  one-hot grant, registered.
REQ-006 gnt_id  output  2  binary index of the granted requester, the 4:2 encoding of gnt, registered.
REQ-007 gnt_valid  output  1  high while any grant is active, registered.
REQ-008 The block SHALL use one clock (clk); reset (rst) SHALL be asynchronous and active-high.

Function
REQ-009 The FSM SHALL have the states IDLE and BUSY.
REQ-010 In IDLE, when req != 0 is sampled at a rising edge, the block SHALL grant at that edge (one-cycle latency) and enter BUSY.
REQ-011 Winner selection SHALL scan ptr, ptr+1, ptr+2, ptr+3 (mod 4), and the first requester found with req set SHALL win.
REQ-012 On every new grant, ptr SHALL become winner+1 mod 4, so that 3 wraps to 0.
REQ-013 In BUSY, the grant SHALL hold while req[owner]=1.
REQ-014 When req[owner]=0 is sampled and another request is pending, the block SHALL grant the next winner at the same edge with no idle cycle; gnt SHALL be one-hot at all times, never two-hot.
REQ-015 When req[owner]=0 is sampled and no other request is pending, gnt SHALL go to 0 and the FSM SHALL return to IDLE.
REQ-016 A request deasserted before it is granted SHALL be forgotten; there SHALL be no request latching.
REQ-017 When gnt_valid=0, gnt_id SHALL be 0; when gnt_valid=1, gnt_id SHALL equal the index of the single set bit of gnt.
REQ-018 A hold counter SHALL clear on each new grant and increment each BUSY cycle, saturating at MAX_HOLD.
REQ-019 If all four requesters assert continuously from reset and each drops its request one cycle after being granted, the grant order SHALL be 0,1,2,3,0,...

Reset
REQ-020 Asserting rst SHALL immediately, without waiting for a clock edge, set gnt=0, gnt_id=0, gnt_valid=0, state=IDLE, ptr=0, and hold counter=0.
REQ-021 A reset asserted mid-grant SHALL drop the grant asynchronously.
REQ-022 After rst deasserts, the first arbitration SHALL start its scan at requester 0.

Configuration
REQ-023 With RR_ARB_TIMEOUT_EN defined, when the hold counter equals MAX_HOLD and any other request is pending, the block SHALL revoke the owner's grant and grant the next winner at that edge; the revoked owner SHALL re-arbitrate normally.
REQ-024 With RR_ARB_TIMEOUT_EN defined, if no other request is pending, the owner SHALL keep its grant past MAX_HOLD.
REQ-025 Without RR_ARB_TIMEOUT_EN, the hold counter SHALL NOT be synthesized, MAX_HOLD SHALL be ignored, and a grant SHALL be held until the owner's request drops.

Structure
REQ-026 Package rr_arbiter4_pkg SHALL hold NUM_REQ=4, ID_W=2, and the state enum (IDLE, BUSY).
REQ-027 Rotating-priority selection SHALL be a combinational sub-module, rr_pick4 (inputs req[3:0] and ptr[1:0]; outputs one-hot pick[3:0] and pick_id[1:0]).
REQ-028 All outputs SHALL come directly from flops.

Verification
REQ-029 Reset, then req=4'b0100 -> the next edge gives gnt=4'b0100, gnt_id=2, gnt_valid=1, and ptr=3.
REQ-030 req=4'b1111 held from reset, each owner dropping its request one cycle after being granted -> gnt_id sequence 0,1,2,3,0 with no idle cycle between grants.
REQ-031 Owner 1 holds while req=4'b1010; owner drops req[1] -> the same edge gives gnt=4'b1000, gnt_id=3; then req=0 -> gnt=0, gnt_id=0, IDLE.
REQ-032 rst pulsed mid-BUSY between clock edges -> gnt=0, gnt_id=0, gnt_valid=0 without a clock edge; after release, req=4'b1001 -> gnt_id=0.
REQ-033 With RR_ARB_TIMEOUT_EN and MAX_HOLD=4, owner 2 holds while req=4'b0101 -> gnt moves to requester 0 after 4 BUSY cycles; owner 2 alone -> keeps its grant indefinitely.
REQ-034 Without RR_ARB_TIMEOUT_EN, the same stimulus as REQ-033 -> owner 2 keeps its grant until req[2]=0.

Source files
------------

// File: rtl/rr_arbiter4_pkg.sv
// Shared constants and types for the 4-way round-robin arbiter.
// Holds requester count, grant index width and the FSM state encoding.
package rr_arbiter4_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter4_pick.sv
// rr_pick4: combinational rotating-priority selector.
// Ports: req[3:0], ptr[1:0] in; one-hot pick[3:0], pick_id[1:0] out.
module rr_pick4
    import rr_arbiter4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [ID_W-1:0]    pick_id
);

    logic [ID_W-1:0] idx;
    logic            found;

    // Scan ptr, ptr+1, ptr+2, ptr+3 (mod 4); first set request wins.
    always_comb begin
        pick    = '0;
        pick_id = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + ID_W'(k);
            if (!found && req[idx]) begin
                found     = 1'b1;
                pick_id   = idx;
                pick[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-requester round-robin arbiter with registered grants.
// Ports: clk, rst (async high), req[3:0] in; gnt[3:0], gnt_id[1:0],
// gnt_valid out. Macro RR_ARB_TIMEOUT_EN enables MAX_HOLD revocation.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid
);

    generate
        if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
            $error("MAX_HOLD out of range 1..255");
        end
    endgenerate

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    ptr_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [ID_W-1:0]    gnt_id_nxt;
    logic               gnt_valid_nxt;
    logic               new_grant;

    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] pick;
    logic [ID_W-1:0]    pick_id;
    logic               owner_req;
    logic               others;

    // While busy the owner is masked out so a revocation never
    // re-selects it; when the owner has dropped this equals req.
    assign pick_req  = (state == BUSY) ? (req & ~gnt) : req;
    assign owner_req = req[gnt_id];
    assign others    = |(req & ~gnt);

    rr_pick4 u_pick (
        .req     (pick_req),
        .ptr     (ptr),
        .pick    (pick),
        .pick_id (pick_id)
    );

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] hold;
    logic       expired;

    assign expired = (hold == 8'(MAX_HOLD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
        end else if (new_grant) begin
            hold <= '0;
        end else if (state == BUSY && !expired) begin
            hold <= hold + 8'd1;
        end
    end
`else
    logic expired;

    assign expired = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        gnt_nxt       = gnt;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        new_grant     = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    new_grant = 1'b1;
                end
            end
            BUSY: begin
                if (owner_req) begin
                    if (expired && others) begin
                        new_grant = 1'b1;
                    end
                end else if (others) begin
                    new_grant = 1'b1;
                end else begin
                    state_nxt     = IDLE;
                    gnt_nxt       = '0;
                    gnt_id_nxt    = '0;
                    gnt_valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (new_grant) begin
            state_nxt     = BUSY;
            gnt_nxt       = pick;
            gnt_id_nxt    = pick_id;
            gnt_valid_nxt = 1'b1;
            ptr_nxt       = pick_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed self-checking bench for rr_arbiter4.
// Expected values are hand-computed per step.
module tb_rr_arbiter4;
    import rr_arbiter4_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    int n_assert = 0;
    int n_fail   = 0;

    rr_arbiter4 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_g(input string tag, input logic [3:0] g,
                         input logic [1:0] id, input logic v);
        chk({tag, ".gnt"}, 8'(gnt), 8'(g));
        chk({tag, ".id"}, 8'(gnt_id), 8'(id));
        chk({tag, ".valid"}, 8'(gnt_valid), 8'(v));
    endtask

    initial begin
        #1;
        chk_g("reset", 4'b0000, 2'd0, 1'b0);
        chk("reset.ptr", 8'(dut.ptr), 8'd0);
        chk("reset.state", 8'(dut.state), 8'(IDLE));
        edge1();
        edge1();
        rst = 1'b0;

        // single request 2
        req = 4'b0100;
        edge1();
        chk_g("single2", 4'b0100, 2'd2, 1'b1);
        chk("single2.ptr", 8'(dut.ptr), 8'd3);
        req = 4'b0000;
        edge1();
        chk_g("release2", 4'b0000, 2'd0, 1'b0);
        chk("release2.state", 8'(dut.state), 8'(IDLE));

        // all requesting from reset, owner drops once granted
        rst = 1'b1;
        #1;
        rst = 1'b0;
        req = 4'b1111;
        edge1();
        chk_g("rr0", 4'b0001, 2'd0, 1'b1);
        req = ~gnt;
        edge1();
        chk_g("rr1", 4'b0010, 2'd1, 1'b1);
        req = ~gnt;
        edge1();
        chk_g("rr2", 4'b0100, 2'd2, 1'b1);
        req = ~gnt;
        edge1();
        chk_g("rr3", 4'b1000, 2'd3, 1'b1);
        chk("rr3.ptr", 8'(dut.ptr), 8'd0);
        req = ~gnt;
        edge1();
        chk_g("rr4", 4'b0001, 2'd0, 1'b1);

        // owner 1 holds, then hands over to 3 with no gap
        req = 4'b1010;
        edge1();
        chk_g("own1", 4'b0010, 2'd1, 1'b1);
        edge1();
        chk_g("own1.hold", 4'b0010, 2'd1, 1'b1);
        req = 4'b1000;
        edge1();
        chk_g("hand3", 4'b1000, 2'd3, 1'b1);
        req = 4'b0000;
        edge1();
        chk_g("idle", 4'b0000, 2'd0, 1'b0);
        chk("idle.state", 8'(dut.state), 8'(IDLE));

        // async reset between edges
        req = 4'b0010;
        edge1();
        chk_g("pre_rst", 4'b0010, 2'd1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_g("async_rst", 4'b0000, 2'd0, 1'b0);
        chk("async_rst.ptr", 8'(dut.ptr), 8'd0);
        rst = 1'b0;
        req = 4'b1001;
        edge1();
        chk_g("post_rst", 4'b0001, 2'd0, 1'b1);

        // owner 2 holding against requester 0
        req = 4'b0000;
        edge1();
        chk_g("idle2", 4'b0000, 2'd0, 1'b0);
        req = 4'b0100;
        edge1();
        chk_g("own2", 4'b0100, 2'd2, 1'b1);
        req = 4'b0101;
`ifdef RR_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            edge1();
            chk_g("to.hold", 4'b0100, 2'd2, 1'b1);
        end
        edge1();
        chk_g("to.revoke", 4'b0001, 2'd0, 1'b1);
        req = 4'b0100;
        edge1();
        chk_g("to.back2", 4'b0100, 2'd2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            edge1();
            chk_g("to.alone", 4'b0100, 2'd2, 1'b1);
        end
        req = 4'b0000;
        edge1();
        chk_g("to.end", 4'b0000, 2'd0, 1'b0);
`else
        for (int i = 0; i < 12; i++) begin
            edge1();
            chk_g("nto.hold", 4'b0100, 2'd2, 1'b1);
        end
        req = 4'b0001;
        edge1();
        chk_g("nto.hand0", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        edge1();
        chk_g("nto.end", 4'b0000, 2'd0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
